stage2_context_run: RTL

STAGE2_CONTEXT_RUN -- requirements
Module: stage2_context_run

---
 rtl/stage2_context_run_pkg.sv | 24 ++
 rtl/stage2_context_run_gradient_quantizer.sv | 34 +++
 rtl/stage2_context_run.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/stage2_context_run_pkg.sv
// JPEG-LS stage 2 shared parameters: widths,
// gradient thresholds, mode codes, run state.
package stage2_context_run_pkg;

  localparam int PIXEL_LEN  = 8;
  localparam int RUNCNT_LEN = 16;
  localparam int RUNVAL_LEN = 8;
  localparam int Q_LEN      = 4;
  localparam int MODE_LEN   = 2;
  localparam int GRAD_T1    = 3;
  localparam int GRAD_T2    = 7;
  localparam int GRAD_T3    = 21;

  localparam logic [1:0] MODE_REGULAR = 2'b00;
  localparam logic [1:0] MODE_RUN_CNT = 2'b01;
  localparam logic [1:0] MODE_RUN_EOL = 2'b10;
  localparam logic [1:0] MODE_RUN_INT = 2'b11;

  typedef enum logic {
    ST_REGULAR = 1'b0,
    ST_IN_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/stage2_context_run_gradient_quantizer.sv
// Gradient quantizer: signed D (d_i) -> Q in -4..4
// (q_o, two's complement) using thresholds T1/T2/T3.
module gradient_quantizer #(
  parameter int DW = 9,
  parameter int QW = 4,
  parameter int T1 = 3,
  parameter int T2 = 7,
  parameter int T3 = 21
) (
  input  logic signed [DW-1:0] d_i,
  output logic signed [QW-1:0] q_o
);

  localparam logic signed [DW-1:0] P1 = DW'(T1);
  localparam logic signed [DW-1:0] P2 = DW'(T2);
  localparam logic signed [DW-1:0] P3 = DW'(T3);
  localparam logic signed [DW-1:0] N1 = -P1;
  localparam logic signed [DW-1:0] N2 = -P2;
  localparam logic signed [DW-1:0] N3 = -P3;

  always_comb begin
    q_o = '0;
    if (d_i <= N3)       q_o = QW'(-4);
    else if (d_i <= N2)  q_o = QW'(-3);
    else if (d_i <= N1)  q_o = QW'(-2);
    else if (d_i[DW-1])  q_o = QW'(-1);
    else if (d_i == '0)  q_o = '0;
    else if (d_i < P1)   q_o = QW'(1);
    else if (d_i < P2)   q_o = QW'(2);
    else if (d_i < P3)   q_o = QW'(3);
    else                 q_o = QW'(4);
  end

endmodule

// File: rtl/stage2_context_run.sv
// JPEG-LS context/run stage: pixels a/b/c/d/x in,
// quantized context, sign, mode and run info out.
module stage2_context_run
  import stage2_context_run_pkg::*;
#(
  parameter int pixel_length      = PIXEL_LEN,
  parameter int runcount_length   = RUNCNT_LEN,
  parameter int runvalue_length   = RUNVAL_LEN,
  parameter int quantizedQ_length = Q_LEN,
  parameter int mode_length       = MODE_LEN,
  parameter int T1                = GRAD_T1,
  parameter int T2                = GRAD_T2,
  parameter int T3                = GRAD_T3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_enc_2,
  input  logic [pixel_length-1:0]      a_2,
  input  logic [pixel_length-1:0]      b_2,
  input  logic [pixel_length-1:0]      c_2,
  input  logic [pixel_length-1:0]      d_2,
  input  logic [pixel_length-1:0]      x_2,
  input  logic                         EOL_2,
  input  logic                         EOF_2,
  output logic [quantizedQ_length-1:0] Q_1_2,
  output logic [quantizedQ_length-1:0] Q_2_2,
  output logic [quantizedQ_length-1:0] Q_3_2,
  output logic                         sign_2,
  output logic [mode_length-1:0]       mode_2,
  output logic [runcount_length-1:0]   run_count_2,
  output logic [runvalue_length-1:0]   run_value_2,
  output logic                         RIType_2,
  output logic                         a_b_compare_2
);

  localparam int DW = pixel_length + 1;
  localparam int QW = quantizedQ_length;
  localparam int CW = runcount_length;
  localparam int VW = runvalue_length;
  localparam int MW = mode_length;

  run_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [VW-1:0] rv_q, rv_d;

  logic signed [DW-1:0] d1, d2, d3;
  logic signed [QW-1:0] q1, q2, q3;
  logic ctx_sign;
  logic q_zero;
  logic in_run;
  logic match;
  logic ri;
  logic [VW-1:0] rv_eff;
  logic [CW-1:0] cnt_inc;

  assign d1 = $signed({1'b0, d_2}) - $signed({1'b0, b_2});
  assign d2 = $signed({1'b0, b_2}) - $signed({1'b0, c_2});
  assign d3 = $signed({1'b0, c_2}) - $signed({1'b0, a_2});

  gradient_quantizer #(
    .DW(DW), .QW(QW), .T1(T1), .T2(T2), .T3(T3)
  ) u_gq1 (.d_i(d1), .q_o(q1));

  gradient_quantizer #(
    .DW(DW), .QW(QW), .T1(T1), .T2(T2), .T3(T3)
  ) u_gq2 (.d_i(d2), .q_o(q2));

  gradient_quantizer #(
    .DW(DW), .QW(QW), .T1(T1), .T2(T2), .T3(T3)
  ) u_gq3 (.d_i(d3), .q_o(q3));

  // sign of first non-zero Q; a zero q3 has msb 0
  assign ctx_sign = (q1 != '0) ? q1[QW-1] :
                    (q2 != '0) ? q2[QW-1] :
                                 q3[QW-1];

  assign Q_1_2 = ctx_sign ? -q1 : q1;
  assign Q_2_2 = ctx_sign ? -q2 : q2;
  assign Q_3_2 = ctx_sign ? -q3 : q3;

  assign a_b_compare_2 = (a_2 > b_2);

  assign q_zero = (q1 == '0) && (q2 == '0) &&
                  (q3 == '0);
  assign in_run = (state_q == ST_IN_RUN) || q_zero;

  // entry pixel uses Ra as run value before latch
  assign rv_eff = (state_q == ST_IN_RUN) ?
                  rv_q : VW'(a_2);
  assign match  = (VW'(x_2) == rv_eff);

  assign cnt_inc = (count_q == '1) ? count_q :
                   count_q + {{(CW-1){1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rv_d        = rv_q;
    mode_2      = MW'(MODE_REGULAR);
    run_count_2 = '0;
    run_value_2 = rv_q;
    RIType_2    = 1'b0;
    sign_2      = ctx_sign;
    ri          = (a_2 == b_2);
    if (in_run) begin
      run_value_2 = rv_eff;
      rv_d        = rv_eff;
      if (!match) begin
        mode_2      = MW'(MODE_RUN_INT);
        run_count_2 = count_q;
        count_d     = '0;
        state_d     = ST_REGULAR;
        RIType_2    = ri;
        sign_2      = !ri && (a_2 > b_2);
      end else if (EOL_2 || EOF_2) begin
        mode_2      = MW'(MODE_RUN_EOL);
        run_count_2 = cnt_inc;
        count_d     = '0;
        state_d     = ST_REGULAR;
      end else begin
        mode_2      = MW'(MODE_RUN_CNT);
        run_count_2 = cnt_inc;
        count_d     = cnt_inc;
        state_d     = ST_IN_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_REGULAR;
      count_q <= '0;
      rv_q    <= '0;
    end else if (start_enc_2) begin
      state_q <= state_d;
      count_q <= count_d;
      rv_q    <= rv_d;
    end
  end

endmodule
